// File: rtl/counter_timer_ctrl_pkg.sv
// Shared encodings and defaults for the interval-timer controller.
package counter_timer_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] S_RUN    = 3'd2;
    localparam logic [STATE_W-1:0] S_PAUSED = 3'd3;
    localparam logic [STATE_W-1:0] S_ALARM  = 3'd4;

    localparam int DEFAULT_ALARM_TICKS = 4;
    localparam int ALARM_CNT_W         = 4;

endpackage

// File: rtl/counter_timer_ctrl_edge_detect.sv
// One-cycle pulse on a rising or falling transition of a level input.
module edge_detect #(
    parameter bit RISING = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;
    logic armed_q;

    // armed_q masks the first cycle after reset so a level already held
    // when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= 1'b1;
        end
    end

    assign pulse_o = armed_q & (RISING ? (sig_i & ~prev_q) : (~sig_i & prev_q));

endmodule

// File: rtl/counter_timer_ctrl.sv
// Interval-timer sequencer driving an up/down counter with built-in divider:
// load preset, count to target, pause/resume, timed alarm, optional reload.
module counter_timer_ctrl
    import counter_timer_ctrl_pkg::*;
#(
    parameter int ALARM_TICKS = DEFAULT_ALARM_TICKS,
    parameter int WIDTH       = 4
) (
    input  logic               iClk,
    input  logic               inReset,
    input  logic               iStart,
    input  logic               iPause,
    input  logic               iClear,
    input  logic               iDir,
    input  logic               iAutoReload,
    input  logic [WIDTH-1:0]   iPreset,
    input  logic               iClk_div,
    input  logic [WIDTH-1:0]   iCount_out,
    output logic               oLoad,
    output logic               oCount_en,
    output logic               oUp,
    output logic [WIDTH-1:0]   oCount_in,
    output logic               oAlarm,
    output logic               oDone,
    output logic [STATE_W-1:0] oState
);

    localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_TICKS - 1);

    logic start_ev, pause_ev, clear_ev, tick;

    edge_detect #(.RISING(1'b1)) u_start (
        .clk_i(iClk), .rst_ni(inReset), .sig_i(iStart), .pulse_o(start_ev));
    edge_detect #(.RISING(1'b1)) u_pause (
        .clk_i(iClk), .rst_ni(inReset), .sig_i(iPause), .pulse_o(pause_ev));
    edge_detect #(.RISING(1'b1)) u_clear (
        .clk_i(iClk), .rst_ni(inReset), .sig_i(iClear), .pulse_o(clear_ev));
    edge_detect #(.RISING(1'b0)) u_tick (
        .clk_i(iClk), .rst_ni(inReset), .sig_i(iClk_div), .pulse_o(tick));

    logic [STATE_W-1:0]     state_q, state_d;
    logic                   dir_q, dir_d;
    logic [WIDTH-1:0]       preset_q, preset_d;
    logic [WIDTH-1:0]       target_q, target_d;
    logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic                   load_armed_q;

    logic                   load_d, count_en_d, up_d, alarm_d, done_d;
    logic [WIDTH-1:0]       count_in_d;

    logic                   load_q, count_en_q, up_q, alarm_q, done_q;
    logic [WIDTH-1:0]       count_in_q;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        preset_d    = preset_q;
        target_d    = target_q;
        alarm_cnt_d = alarm_cnt_q;

        if (clear_ev) begin
            state_d     = S_IDLE;
            alarm_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ev && (iPreset != '0)) begin
                        dir_d    = iDir;
                        preset_d = iPreset;
                        target_d = iDir ? iPreset : '0;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The tick seen here lags the counter's own edge by one
                    // cycle, so only trust it once oLoad was already presented.
                    if (tick && load_armed_q) state_d = S_RUN;
                end
                S_RUN: begin
                    if (iCount_out == target_q) state_d = S_ALARM;
                    else if (pause_ev)          state_d = S_PAUSED;
                end
                S_PAUSED: begin
                    if (pause_ev) state_d = S_RUN;
                end
                S_ALARM: begin
                    if (start_ev) begin
                        alarm_cnt_d = '0;
                        if (iPreset != '0) begin
                            dir_d    = iDir;
                            preset_d = iPreset;
                            target_d = iDir ? iPreset : '0;
                            state_d  = S_LOAD;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else if (tick) begin
                        if (alarm_cnt_q == ALARM_LAST) begin
                            alarm_cnt_d = '0;
                            state_d     = iAutoReload ? S_LOAD : S_IDLE;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    alarm_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_comb begin
        load_d     = (state_d == S_LOAD);
        count_en_d = (state_d == S_LOAD) || (state_d == S_RUN);
        up_d       = dir_d && ((state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSED));
        count_in_d = ((state_d == S_IDLE) || dir_d) ? '0 : preset_d;
        alarm_d    = (state_d == S_ALARM);
        done_d     = (state_d == S_ALARM) && (state_q != S_ALARM);
    end

    always_ff @(posedge iClk or negedge inReset) begin
        if (!inReset) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            preset_q     <= '0;
            target_q     <= '0;
            alarm_cnt_q  <= '0;
            load_armed_q <= 1'b0;
            load_q       <= 1'b0;
            count_en_q   <= 1'b0;
            up_q         <= 1'b0;
            count_in_q   <= '0;
            alarm_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            preset_q     <= preset_d;
            target_q     <= target_d;
            alarm_cnt_q  <= alarm_cnt_d;
            load_armed_q <= (state_q == S_LOAD) && (state_d == S_LOAD);
            load_q       <= load_d;
            count_en_q   <= count_en_d;
            up_q         <= up_d;
            count_in_q   <= count_in_d;
            alarm_q      <= alarm_d;
            done_q       <= done_d;
        end
    end

    assign oLoad     = load_q;
    assign oCount_en = count_en_q;
    assign oUp       = up_q;
    assign oCount_in = count_in_q;
    assign oAlarm    = alarm_q;
    assign oDone     = done_q;
    assign oState    = state_q;

endmodule
